// File: rtl/data_mem_pkg.sv
// Shared types and helpers for the multi-port data memory: FSM state encoding,
// the default clear value and packed-bus slice arithmetic.
package data_mem_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } mem_state_e;

    localparam int DEFAULT_CLEAR_VAL = 0;

    // Low bit index of slice idx in a bus made of equal width-bit fields.
    function automatic int slice_lo(input int idx, input int width);
        return idx * width;
    endfunction

endpackage

// File: rtl/data_mem_rd_port.sv
// One registered read port: range check, write-first bypass, and the output
// data/valid registers. The data register holds when the port is not reading.
module data_mem_rd_port #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 6,
    parameter int DEPTH  = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_rd_go,
    input  logic [ADDR_W-1:0] i_rd_addr,
    input  logic [DATA_W-1:0] i_mem_word,
    input  logic              i_wr_go,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    output logic [DATA_W-1:0] o_rd_data,
    output logic              o_rd_valid
);

    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

    logic              w_in_range;
    logic              w_hit;
    logic [DATA_W-1:0] w_word;
    logic [DATA_W-1:0] r_rd_data;
    logic              r_rd_valid;

    assign w_in_range = ({1'b0, i_rd_addr} < DEPTH_L);
    assign w_hit      = i_wr_go && (i_wr_addr == i_rd_addr);

    always_comb begin
        w_word = '0;
        if (w_in_range) begin
            w_word = w_hit ? i_wr_data : i_mem_word;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= i_rd_go;
            if (i_rd_go) begin
                r_rd_data <= w_word;
            end
        end
    end

    assign o_rd_data  = r_rd_data;
    assign o_rd_valid = r_rd_valid;

endmodule

// File: rtl/data_mem_mp.sv
// Multi-port data memory: one write port, N_RD registered read ports, and a
// sequencer that walks the array writing CLEAR_VAL after reset or on request.
module data_mem_mp
    import data_mem_pkg::*;
#(
    parameter int              DATA_W    = 8,
    parameter int              ADDR_W    = 6,
    parameter int              DEPTH     = 64,
    parameter int              N_RD      = 2,
    parameter logic [DATA_W-1:0] CLEAR_VAL = DATA_W'(DEFAULT_CLEAR_VAL)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     enable,
    input  logic                     clear,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic [N_RD-1:0]          rd_en,
    input  logic [N_RD*ADDR_W-1:0]   rd_addr,
    output logic [N_RD*DATA_W-1:0]   rd_data,
    output logic [N_RD-1:0]          rd_valid,
    output logic                     busy
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   DEPTH_L   = (ADDR_W + 1)'(DEPTH);

    mem_state_e        r_state;
    mem_state_e        w_state_next;
    logic [ADDR_W-1:0] r_ptr;
    logic [ADDR_W-1:0] w_ptr_next;
    logic              w_accept;
    logic              w_wr_go;
    logic [DATA_W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= CLEAR;
            r_ptr   <= '0;
        end else begin
            r_state <= w_state_next;
            r_ptr   <= w_ptr_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_ptr_next   = r_ptr;
        case (r_state)
            CLEAR: begin
                w_ptr_next = r_ptr + 1'b1;
                if (r_ptr == LAST_ADDR) begin
                    w_state_next = READY;
                    w_ptr_next   = '0;
                end
            end
            READY: begin
                if (clear) begin
                    w_state_next = CLEAR;
                    w_ptr_next   = '0;
                end
            end
            default: begin
                w_state_next = CLEAR;
                w_ptr_next   = '0;
            end
        endcase
    end

    // A clear request wins over any access presented in the same cycle.
    assign w_accept = (r_state == READY) && enable && !clear;
    assign w_wr_go  = w_accept && wr_en && ({1'b0, wr_addr} < DEPTH_L);
    assign busy     = (r_state == CLEAR);

    // Array has no reset; contents survive rst and are rewritten by the sequencer.
    always_ff @(posedge clk) begin
        if (rst && (r_state == CLEAR)) begin
            r_mem[r_ptr] <= CLEAR_VAL;
        end else if (w_wr_go) begin
            r_mem[wr_addr] <= wr_data;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < N_RD; gi++) begin : g_rd
            logic [ADDR_W-1:0] w_addr;
            logic [DATA_W-1:0] w_word;

            assign w_addr = rd_addr[slice_lo(gi, ADDR_W) +: ADDR_W];
            assign w_word = r_mem[w_addr];

            data_mem_rd_port #(
                .DATA_W (DATA_W),
                .ADDR_W (ADDR_W),
                .DEPTH  (DEPTH)
            ) u_rd_port (
                .clk        (clk),
                .rst        (rst),
                .i_rd_go    (w_accept && rd_en[gi]),
                .i_rd_addr  (w_addr),
                .i_mem_word (w_word),
                .i_wr_go    (w_wr_go),
                .i_wr_addr  (wr_addr),
                .i_wr_data  (wr_data),
                .o_rd_data  (rd_data[slice_lo(gi, DATA_W) +: DATA_W]),
                .o_rd_valid (rd_valid[gi])
            );
        end
    endgenerate

endmodule
